// File: rtl/simplez_kbd_rx.sv
// Keyboard-side UART 8N1 receiver for the simplez CPU bus.
// Polled status word plus data word. Reading the data word clears all flags.
module simplez_kbd_rx #(
  parameter int unsigned BAUD_DIV    = 104,
  parameter logic [8:0]  ADDR_STATUS = 9'd508,
  parameter logic [8:0]  ADDR_DATA   = 9'd509
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [8:0]  addr,
  input  logic        rd,
  output logic [11:0] dout,
  input  logic        rx,
  output logic        rx_led
);

  localparam int unsigned   CW   = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    hold, hold_n;
  logic          ready, ready_n;
  logic          ovr, ovr_n;
  logic          ferr, ferr_n;
  logic          wait_high, wait_high_n;
  logic [11:0]   dout_n;
  logic          sync1, rxs;
  logic          status_rd, data_rd;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1     <= 1'b1;
      rxs       <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      hold      <= '0;
      ready     <= 1'b0;
      ovr       <= 1'b0;
      ferr      <= 1'b0;
      wait_high <= 1'b0;
      dout      <= '0;
    end else begin
      sync1     <= rx;
      rxs       <= sync1;
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      hold      <= hold_n;
      ready     <= ready_n;
      ovr       <= ovr_n;
      ferr      <= ferr_n;
      wait_high <= wait_high_n;
      dout      <= dout_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_idx_n   = bit_idx;
    shift_n     = shift;
    hold_n      = hold;
    ready_n     = ready;
    ovr_n       = ovr;
    ferr_n      = ferr;
    wait_high_n = wait_high;

    status_rd = rd && (addr == ADDR_STATUS);
    data_rd   = rd && (addr == ADDR_DATA);

    if (status_rd)    dout_n = {9'b0, ferr, ovr, ready};
    else if (data_rd) dout_n = {4'b0, hold};
    else              dout_n = '0;

    // Clear first so that a same-edge commit or framing error overrides it.
    if (data_rd) begin
      ready_n = 1'b0;
      ovr_n   = 1'b0;
      ferr_n  = 1'b0;
    end

    case (state)
      IDLE: begin
        if (wait_high) begin
          if (rxs) wait_high_n = 1'b0;
        end else if (!rxs) begin
          cnt_n   = HALF;
          state_n = START;
        end
      end
      START: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (!rxs) begin
          bit_idx_n = '0;
          cnt_n     = FULL;
          state_n   = DATA;
        end else begin
          state_n = IDLE;
        end
      end
      DATA: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          shift_n   = {rxs, shift[7:1]};
          cnt_n     = FULL;
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          state_n = IDLE;
          if (rxs) begin
            hold_n  = shift;
            ready_n = 1'b1;
            if (ready && !data_rd) ovr_n = 1'b1;
          end else begin
            ferr_n      = 1'b1;
            wait_high_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign rx_led = ready;

endmodule

// File: tb/tb_simplez_kbd_rx.sv
// Bench for simplez_kbd_rx at BAUD_DIV=4: directed bus/frame scenarios plus
// random frames and bus accesses checked against a flag-level reference model.
module tb_simplez_kbd_rx;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [8:0]  addr = '0;
  logic        rd = 1'b0;
  logic [11:0] dout;
  logic        rx = 1'b1;
  logic        rx_led;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model: what the CPU should observe.
  logic [7:0] m_hold;
  logic       m_ready, m_ovr, m_ferr;

  typedef struct {
    logic [8:0]  a;
    logic        r;
    logic [11:0] exp;
  } bus_vec_t;

  bus_vec_t tab[10];

  simplez_kbd_rx #(.BAUD_DIV(4), .ADDR_STATUS(9'd508), .ADDR_DATA(9'd509)) dut (
    .clk(clk), .rstn(rstn), .addr(addr), .rd(rd),
    .dout(dout), .rx(rx), .rx_led(rx_led)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%03h, expected 0x%03h", name, got, exp);
    end
  endtask

  task automatic bus_op(input logic [8:0] a, input logic r, output logic [11:0] d);
    addr = a;
    rd   = r;
    tick();
    rd   = 1'b0;
    addr = '0;
    d    = dout;
  endtask

  task automatic read_chk(input string name, input logic [8:0] a, input logic [11:0] exp);
    logic [11:0] d;
    bus_op(a, 1'b1, d);
    check(name, d, exp);
  endtask

  // Start, 8 data bits LSB-first, stop level; returns just before the stop-sample edge.
  task automatic send_bits(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (4) tick();
    end
    rx = stop;
    repeat (4) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic ok);
    send_bits(b, ok);
    if (!ok) repeat (4) tick();
    rx = 1'b1;
    repeat (4) tick();
  endtask

  task automatic model_frame(input logic [7:0] b, input logic ok);
    if (ok) begin
      if (m_ready) m_ovr = 1'b1;
      m_ready = 1'b1;
      m_hold  = b;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  function automatic logic [11:0] model_bus(input logic [8:0] a, input logic r);
    logic [11:0] e;
    e = '0;
    if (r && a == 9'd508) e = {9'b0, m_ferr, m_ovr, m_ready};
    if (r && a == 9'd509) begin
      e = {4'b0, m_hold};
      m_ready = 1'b0;
      m_ovr   = 1'b0;
      m_ferr  = 1'b0;
    end
    return e;
  endfunction

  initial begin
    logic [11:0] d;
    logic [7:0]  b;
    logic        ok;
    logic [8:0]  a;
    logic        r;
    logic [11:0] e;

    tab[0] = '{9'd508, 1'b1, 12'h001};
    tab[1] = '{9'd510, 1'b1, 12'h000};
    tab[2] = '{9'd509, 1'b0, 12'h000};
    tab[3] = '{9'd508, 1'b1, 12'h001};
    tab[4] = '{9'd507, 1'b1, 12'h000};
    tab[5] = '{9'd000, 1'b1, 12'h000};
    tab[6] = '{9'd511, 1'b0, 12'h000};
    tab[7] = '{9'd509, 1'b1, 12'h041};
    tab[8] = '{9'd508, 1'b1, 12'h000};
    tab[9] = '{9'd509, 1'b1, 12'h041};

    // Reset wins over an active status read and a toggling line.
    rstn = 1'b0;
    addr = 9'd508;
    rd   = 1'b1;
    repeat (2) begin
      rx = ~rx;
      tick();
    end
    check("reset_dout", dout, 12'h000);
    check("reset_led", {11'b0, rx_led}, 12'h000);
    rd   = 1'b0;
    addr = '0;
    rx   = 1'b1;
    rstn = 1'b1;
    repeat (4) tick();
    read_chk("reset_status", 9'd508, 12'h000);

    // Single byte, then address decode table.
    send_frame(8'h41, 1'b1);
    check("byte41_led", {11'b0, rx_led}, 12'h001);
    for (int i = 0; i < 10; i++) begin
      bus_op(tab[i].a, tab[i].r, d);
      check($sformatf("decode[%0d]", i), d, tab[i].exp);
    end

    // Overrun.
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    read_chk("ovr_status", 9'd508, 12'h003);
    read_chk("ovr_data", 9'd509, 12'h0AA);
    read_chk("ovr_status_after", 9'd508, 12'h000);

    // Framing error leaves the holding register alone; line recovers.
    send_frame(8'h33, 1'b0);
    read_chk("ferr_status", 9'd508, 12'h004);
    read_chk("ferr_hold", 9'd509, 12'h0AA);
    read_chk("ferr_cleared", 9'd508, 12'h000);
    send_frame(8'h7E, 1'b1);
    read_chk("after_ferr_status", 9'd508, 12'h001);
    read_chk("after_ferr_data", 9'd509, 12'h07E);

    // One-cycle glitch must not start a frame.
    rx = 1'b0;
    tick();
    rx = 1'b1;
    repeat (12) tick();
    check("glitch_led", {11'b0, rx_led}, 12'h000);
    read_chk("glitch_status", 9'd508, 12'h000);

    // Data read on the commit edge while a byte is already pending.
    send_frame(8'h11, 1'b1);
    send_bits(8'h5A, 1'b1);
    bus_op(9'd509, 1'b1, d);
    check("race_old_byte", d, 12'h011);
    repeat (4) tick();
    read_chk("race_status", 9'd508, 12'h001);
    read_chk("race_new_byte", 9'd509, 12'h05A);
    read_chk("race_clear", 9'd508, 12'h000);

    // Data read on the framing-error edge: set wins over clear.
    send_bits(8'h0F, 1'b0);
    bus_op(9'd509, 1'b1, d);
    check("ferr_race_data", d, 12'h05A);
    repeat (4) tick();
    rx = 1'b1;
    repeat (4) tick();
    read_chk("ferr_race_status", 9'd508, 12'h004);
    read_chk("ferr_race_hold", 9'd509, 12'h05A);

    // Reset in the middle of DATA discards the partial byte.
    rx = 1'b0;
    repeat (4) tick();
    repeat (12) tick();
    rstn = 1'b0;
    rx   = 1'b1;
    tick();
    rstn = 1'b1;
    repeat (48) tick();
    check("midreset_led", {11'b0, rx_led}, 12'h000);
    read_chk("midreset_status", 9'd508, 12'h000);
    read_chk("midreset_hold", 9'd509, 12'h000);

    // Random frames and bus accesses against the model.
    m_hold  = 8'h00;
    m_ready = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
    for (int i = 0; i < 24; i++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(b, ok);
      model_frame(b, ok);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        case ($urandom_range(0, 3))
          0:       a = 9'd508;
          1:       a = 9'd509;
          default: a = 9'($urandom);
        endcase
        r = ($urandom_range(0, 3) != 0);
        e = model_bus(a, r);
        bus_op(a, r, d);
        check($sformatf("rand[%0d] addr=%0d rd=%0d", i, a, r), d, e);
      end
      check($sformatf("rand_led[%0d]", i), {11'b0, rx_led}, {11'b0, m_ready});
    end
    e = model_bus(9'd508, 1'b1);
    read_chk("rand_final_status", 9'd508, e);
    e = model_bus(9'd509, 1'b1);
    read_chk("rand_final_data", 9'd509, e);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/simplez_kbd_rx.md
Name: simplez_kbd_rx

Overview:
Memory-mapped serial input peripheral for the simplez CPU. It sits on the CPU's memory bus as a responder at the two "keyboard" I/O addresses.
- A UART 8N1 receiver deserialises bytes from the `rx` pin into a holding register.
- The CPU polls a status word and then reads a data word.
- It is the input counterpart of the CPU-driven screen/output path and is instantiated next to the CPU in the top level.

Parameters:
BAUD_DIV, 104, clock cycles per bit (12 MHz / 115200); minimum 4.
ADDR_STATUS, 9'd508, bus address of the status word.
ADDR_DATA, 9'd509, bus address of the data word.

Ports:
clk  input  1  system clock; all logic on rising edge.
rstn  input  1  synchronous active-low reset.
addr  input  9  CPU bus address.
rd  input  1  CPU read strobe; one cycle per read.
dout  output  12  read data to CPU; 0 when not selected.
rx  input  1  asynchronous serial line, idle high.
rx_led  output  1  copy of the ready flag, for a board LED.

Behaviour:
- Reset is sampled on rising clk with rstn=0 and wins over all other activity.
- Reset values: FSM=IDLE; ready=0, ovr=0, ferr=0; holding register=0; dout=0; rx_led=0; synchroniser flops=1.
- An abort mid-frame discards the partial byte.

Input path:
- `rx` passes through a 2-flop synchroniser, giving rxs.
- Each bit is sampled once at its midpoint.

FSM:
- IDLE: stays while rxs=1. On rxs=0, load the baud counter with BAUD_DIV/2−1 (integer division) and go to START.
- START: when the counter reaches 0, if rxs=0 go to DATA with bit index 0 and counter BAUD_DIV−1. Otherwise the start was a glitch; return to IDLE with no flag change.
- DATA: at each counter expiry, shift rxs into the shift register LSB-first and reload the counter to BAUD_DIV−1. After bit 7, go to STOP.
- STOP: at counter expiry, if rxs=1 then commit: holding ← shift, ready ← 1. If ready was already 1 and not being cleared that cycle, set ovr ← 1. If rxs=0, discard the byte, set ferr ← 1, and leave the holding register and ready unchanged. Both paths go to IDLE.
- After a framing error, IDLE waits for rxs=1 before it can accept a new start, so no immediate re-trigger on a stuck-low line.

Bus side:
- Read latency is 1 cycle: dout is registered from the addr/rd of the previous cycle.
- rd=1 with addr=ADDR_STATUS: next cycle dout = {9'b0, ferr, ovr, ready}. No side effects.
- rd=1 with addr=ADDR_DATA: next cycle dout = {4'b0, holding}. In the same clock edge, ready, ovr and ferr are cleared.
- rd=0, or any other address: next cycle dout = 12'd0, so the CPU bus can OR peripheral outputs.

Simultaneous events:
- Commit and data read on the same edge: the read returns the old byte, the new byte is loaded, ready stays 1, and ovr is not set.
- Framing error and data read on the same edge: ferr ends at 1, because the set wins over the clear.

Width rule:
- The baud counter is $clog2(BAUD_DIV) bits wide and never wraps below 0.

rx_led = ready.

Test Plan:
All scenarios use BAUD_DIV=4.
1. Reset: hold rstn=0 for 2 cycles while rx toggles → dout=0, rx_led=0, status read returns 0x000.
2. Single byte: send 0x41 (start, 1000 0010 LSB-first, stop) → ready=1 by about 40 cycles after the start edge; status read returns 0x001; data read returns 0x041; a following status read returns 0x000.
3. Overrun: send 0x55 then 0xAA without reading → status returns 0x003; data read returns 0x0AA; status afterwards returns 0x000.
4. Framing error: send 0x33 with stop bit 0 (line held low 2 bit-times, then high) → status returns 0x004; holding register unchanged; a later valid 0x7E is received normally.
5. Glitch and decode: a 1-cycle low pulse on rx → no ready. A rd to address 510 → dout=0. A rd=0 cycle with addr=509 → dout=0 and ready not cleared.
6. Races and mid-frame reset:
   - A data read on the exact STOP-commit cycle → old byte returned, ready=1, ovr=0.
   - rstn=0 asserted during DATA → FSM returns to IDLE and no byte is committed.
